// File: rtl/cpu_types.sv
// Shared CPU-bench types: store-width encoding and end-of-test monitor status.
package cpu_types;

    typedef enum logic [1:0] {
        MEM_MASK_BYTE = 2'd0,
        MEM_MASK_HALF = 2'd1,
        MEM_MASK_WORD = 2'd2
    } memory_mask_t;

    typedef enum logic [2:0] {
        SIM_RUN     = 3'd0,
        SIM_PASS    = 3'd1,
        SIM_FAIL    = 3'd2,
        SIM_TIMEOUT = 3'd3,
        SIM_HANG    = 3'd4
    } sim_status_t;

    localparam logic [31:0] TOHOST_DEFAULT = 32'h0000_0F00;

endpackage

// File: rtl/sim_result_monitor_store_log.sv
// Circular log of the most recent stores; read port indexed relative to the newest entry.
// Writes take effect at the clock edge; the read port is combinational. Never stalls the writer.
module sim_result_monitor_store_log #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [ADDR_W-1:0]          wr_addr,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic [$clog2(DEPTH)-1:0]   rd_idx,
    output logic [ADDR_W-1:0]          rd_addr,
    output logic [DATA_W-1:0]          rd_data,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = IDX_W + 1;

    logic [ADDR_W-1:0] addr_mem_q [DEPTH];
    logic [ADDR_W-1:0] addr_mem_d [DEPTH];
    logic [DATA_W-1:0] data_mem_q [DEPTH];
    logic [DATA_W-1:0] data_mem_d [DEPTH];
    logic [IDX_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [IDX_W-1:0]  rd_ptr;

    always_comb begin
        addr_mem_d = addr_mem_q;
        data_mem_d = data_mem_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        if (wr_en) begin
            addr_mem_d[wr_ptr_q] = wr_addr;
            data_mem_d[wr_ptr_q] = wr_data;
            // Power-of-two depth: the pointer wraps onto the oldest entry by itself.
            wr_ptr_d = wr_ptr_q + IDX_W'(1);
            if (count_q != CNT_W'(DEPTH)) begin
                count_d = count_q + CNT_W'(1);
            end
        end
    end

    always_comb begin
        rd_ptr  = wr_ptr_q - IDX_W'(1) - rd_idx;
        rd_addr = '0;
        rd_data = '0;
        if ({1'b0, rd_idx} < count_q) begin
            rd_addr = addr_mem_q[rd_ptr];
            rd_data = data_mem_q[rd_ptr];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Contents need no reset: entries at or beyond count read back as zero.
    always_ff @(posedge clk) begin
        addr_mem_q <= addr_mem_d;
        data_mem_q <= data_mem_d;
    end

    assign count = count_q;

endmodule

// File: rtl/sim_result_monitor.sv
// End-of-test monitor: snoops stores and pc, decides PASS/FAIL/TIMEOUT/HANG, logs recent stores.
// Decision is registered (visible one edge after the deciding store); purely passive, no backpressure.
module sim_result_monitor
    import cpu_types::*;
#(
    parameter int unsigned         ADDR_W         = 32,
    parameter int unsigned         DATA_W         = 32,
    parameter logic [ADDR_W-1:0]   TOHOST_ADDR    = ADDR_W'(TOHOST_DEFAULT),
    parameter int unsigned         TIMEOUT_CYCLES = 1000,
    parameter int unsigned         HANG_CYCLES    = 16,
    parameter int unsigned         LOG_DEPTH      = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [ADDR_W-1:0]              pc,
    input  logic [ADDR_W-1:0]              memory_address,
    input  logic [DATA_W-1:0]              memory_write,
    input  memory_mask_t                   memory_mask,
    input  logic                           memory_we,
    input  logic [$clog2(LOG_DEPTH)-1:0]   log_idx,
    output logic [ADDR_W-1:0]              log_addr,
    output logic [DATA_W-1:0]              log_data,
    output logic [$clog2(LOG_DEPTH):0]     log_count,
    output logic                           done,
    output sim_status_t                    status,
    output logic [DATA_W-1:0]              exit_code,
    output logic [31:0]                    cycle_count
);
    sim_status_t       state_q, state_d;
    logic [DATA_W-1:0] exit_q, exit_d;
    logic [31:0]       cycle_q, cycle_d;
    logic [31:0]       hang_q, hang_d;
    logic [ADDR_W-1:0] pc_prev_q, pc_prev_d;
    logic              prev_vld_q, prev_vld_d;
    logic              hit;

    always_comb begin
        hit        = memory_we && (memory_address == TOHOST_ADDR) && (memory_mask == MEM_MASK_WORD);
        state_d    = state_q;
        exit_d     = exit_q;
        cycle_d    = cycle_q;
        hang_d     = hang_q;
        pc_prev_d  = pc;
        prev_vld_d = 1'b1;
        if (state_q == SIM_RUN) begin
            hang_d = (prev_vld_q && (pc == pc_prev_q)) ? hang_q + 32'd1 : 32'd0;
            // Even tohost values are deliberately ignored: the test keeps running.
            if (hit && (memory_write == DATA_W'(1))) begin
                state_d = SIM_PASS;
            end else if (hit && memory_write[0]) begin
                state_d = SIM_FAIL;
                exit_d  = memory_write >> 1;
            end else if ((HANG_CYCLES != 0) && (hang_d == 32'(HANG_CYCLES))) begin
                state_d = SIM_HANG;
            end else if ((TIMEOUT_CYCLES != 0) && (cycle_q == 32'(TIMEOUT_CYCLES - 1))) begin
                state_d = SIM_TIMEOUT;
            end
            if (state_d == SIM_RUN) begin
                cycle_d = cycle_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= SIM_RUN;
            exit_q     <= '0;
            cycle_q    <= '0;
            hang_q     <= '0;
            pc_prev_q  <= '0;
            prev_vld_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            exit_q     <= exit_d;
            cycle_q    <= cycle_d;
            hang_q     <= hang_d;
            pc_prev_q  <= pc_prev_d;
            prev_vld_q <= prev_vld_d;
        end
    end

    sim_result_monitor_store_log #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (LOG_DEPTH)
    ) u_store_log (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (memory_we),
        .wr_addr (memory_address),
        .wr_data (memory_write),
        .rd_idx  (log_idx),
        .rd_addr (log_addr),
        .rd_data (log_data),
        .count   (log_count)
    );

    assign status      = state_q;
    assign done        = (state_q != SIM_RUN);
    assign exit_code   = exit_q;
    assign cycle_count = cycle_q;

endmodule

// File: tb/tb_sim_result_monitor.sv
// Directed bench for sim_result_monitor: PASS, FAIL, TIMEOUT, HANG, priorities, store log, reset.
module tb_sim_result_monitor;
    import cpu_types::*;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [31:0]  pc = 32'h100;
    logic [31:0]  memory_address = '0;
    logic [31:0]  memory_write = '0;
    memory_mask_t memory_mask = MEM_MASK_WORD;
    logic         memory_we = 1'b0;
    logic [2:0]   log_idx = '0;
    logic [31:0]  log_addr;
    logic [31:0]  log_data;
    logic [3:0]   log_count;
    logic         done;
    sim_status_t  status;
    logic [31:0]  exit_code;
    logic [31:0]  cycle_count;

    logic hold_pc = 1'b0;
    int   checks = 0;
    int   errors = 0;

    sim_result_monitor #(
        .ADDR_W         (32),
        .DATA_W         (32),
        .TOHOST_ADDR    (32'h0000_0F00),
        .TIMEOUT_CYCLES (50),
        .HANG_CYCLES    (16),
        .LOG_DEPTH      (8)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .pc             (pc),
        .memory_address (memory_address),
        .memory_write   (memory_write),
        .memory_mask    (memory_mask),
        .memory_we      (memory_we),
        .log_idx        (log_idx),
        .log_addr       (log_addr),
        .log_data       (log_data),
        .log_count      (log_count),
        .done           (done),
        .status         (status),
        .exit_code      (exit_code),
        .cycle_count    (cycle_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        if (!hold_pc) pc = pc + 32'd4;
        memory_we   = 1'b0;
        memory_mask = MEM_MASK_WORD;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d, input memory_mask_t m);
        memory_address = a;
        memory_write   = d;
        memory_mask    = m;
        memory_we      = 1'b1;
        tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        ticks(2);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        log_idx = 3'd0;
        #1;
        checks++; if (status !== SIM_RUN) begin errors++; $display("FAIL rst_status got %0d exp %0d", status, SIM_RUN); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done got %0b exp 0", done); end
        checks++; if (exit_code !== 32'd0) begin errors++; $display("FAIL rst_exit got %0d exp 0", exit_code); end
        checks++; if (cycle_count !== 32'd0) begin errors++; $display("FAIL rst_cycle got %0d exp 0", cycle_count); end
        checks++; if (log_count !== 4'd0) begin errors++; $display("FAIL rst_log_count got %0d exp 0", log_count); end
    endtask

    task automatic test_pass();
        do_reset();
        ticks(10);
        checks++; if (cycle_count !== 32'd10) begin errors++; $display("FAIL pass_pre_cycle got %0d exp 10", cycle_count); end
        store(32'hF00, 32'h1, MEM_MASK_WORD);
        checks++; if (status !== SIM_PASS) begin errors++; $display("FAIL pass_status got %0d exp %0d", status, SIM_PASS); end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL pass_done got %0b exp 1", done); end
        checks++; if (cycle_count !== 32'd10) begin errors++; $display("FAIL pass_cycle got %0d exp 10", cycle_count); end
        ticks(5);
        checks++; if (cycle_count !== 32'd10) begin errors++; $display("FAIL pass_frozen got %0d exp 10", cycle_count); end
        checks++; if (status !== SIM_PASS) begin errors++; $display("FAIL pass_sticky got %0d exp %0d", status, SIM_PASS); end
    endtask

    task automatic test_fail();
        do_reset();
        ticks(3);
        store(32'hF00, 32'h2, MEM_MASK_WORD);
        checks++; if (status !== SIM_RUN) begin errors++; $display("FAIL fail_even got %0d exp %0d", status, SIM_RUN); end
        store(32'hF00, 32'h7, MEM_MASK_WORD);
        checks++; if (status !== SIM_FAIL) begin errors++; $display("FAIL fail_status got %0d exp %0d", status, SIM_FAIL); end
        checks++; if (exit_code !== 32'd3) begin errors++; $display("FAIL fail_exit got %0d exp 3", exit_code); end
        store(32'hF00, 32'h1, MEM_MASK_WORD);
        checks++; if (status !== SIM_FAIL) begin errors++; $display("FAIL fail_sticky got %0d exp %0d", status, SIM_FAIL); end
        checks++; if (exit_code !== 32'd3) begin errors++; $display("FAIL fail_exit_kept got %0d exp 3", exit_code); end
        checks++; if (log_count !== 4'd3) begin errors++; $display("FAIL fail_log_count got %0d exp 3", log_count); end
        log_idx = 3'd1; #1;
        checks++; if (log_addr !== 32'hF00 || log_data !== 32'd7) begin errors++; $display("FAIL fail_log_idx1 got (%0h,%0d) exp (f00,7)", log_addr, log_data); end
        log_idx = 3'd5; #1;
        checks++; if (log_addr !== 32'd0 || log_data !== 32'd0) begin errors++; $display("FAIL fail_log_empty got (%0h,%0d) exp (0,0)", log_addr, log_data); end
        log_idx = 3'd0;
    endtask

    task automatic test_timeout();
        int n;
        do_reset();
        store(32'hF00, 32'h1, MEM_MASK_HALF);
        checks++; if (status !== SIM_RUN) begin errors++; $display("FAIL to_halfword got %0d exp %0d", status, SIM_RUN); end
        checks++; if (log_count !== 4'd1) begin errors++; $display("FAIL to_logged got %0d exp 1", log_count); end
        n = 1;
        while (status == SIM_RUN && n < 100) begin
            tick();
            n++;
        end
        checks++; if (status !== SIM_TIMEOUT) begin errors++; $display("FAIL to_status got %0d exp %0d", status, SIM_TIMEOUT); end
        checks++; if (n !== 50) begin errors++; $display("FAIL to_edges got %0d exp 50", n); end
        checks++; if (cycle_count !== 32'd49) begin errors++; $display("FAIL to_cycle got %0d exp 49", cycle_count); end
    endtask

    task automatic test_hang();
        hold_pc = 1'b1;
        pc = 32'h40;
        do_reset();
        ticks(16);
        checks++; if (status !== SIM_RUN) begin errors++; $display("FAIL hang_early got %0d exp %0d", status, SIM_RUN); end
        tick();
        checks++; if (status !== SIM_HANG) begin errors++; $display("FAIL hang_status got %0d exp %0d", status, SIM_HANG); end
        checks++; if (cycle_count !== 32'd16) begin errors++; $display("FAIL hang_cycle got %0d exp 16", cycle_count); end
        hold_pc = 1'b0;
    endtask

    task automatic test_hit_beats_hang();
        hold_pc = 1'b1;
        pc = 32'h40;
        do_reset();
        ticks(16);
        store(32'hF00, 32'h1, MEM_MASK_WORD);
        checks++; if (status !== SIM_PASS) begin errors++; $display("FAIL prio_hit_hang got %0d exp %0d", status, SIM_PASS); end
        hold_pc = 1'b0;
    endtask

    task automatic test_hang_beats_timeout();
        do_reset();
        ticks(33);
        hold_pc = 1'b1;
        ticks(16);
        checks++; if (status !== SIM_RUN || cycle_count !== 32'd49) begin errors++; $display("FAIL prio_pre got (%0d,%0d) exp (0,49)", status, cycle_count); end
        tick();
        checks++; if (status !== SIM_HANG) begin errors++; $display("FAIL prio_hang_to got %0d exp %0d", status, SIM_HANG); end
        hold_pc = 1'b0;
    endtask

    task automatic test_log_wrap();
        do_reset();
        for (int i = 0; i < 10; i++) store(32'(4 * i), 32'(i), MEM_MASK_WORD);
        checks++; if (log_count !== 4'd8) begin errors++; $display("FAIL log_count got %0d exp 8", log_count); end
        log_idx = 3'd0; #1;
        checks++; if (log_addr !== 32'd36 || log_data !== 32'd9) begin errors++; $display("FAIL log_idx0 got (%0d,%0d) exp (36,9)", log_addr, log_data); end
        log_idx = 3'd7; #1;
        checks++; if (log_addr !== 32'd8 || log_data !== 32'd2) begin errors++; $display("FAIL log_idx7 got (%0d,%0d) exp (8,2)", log_addr, log_data); end
        log_idx = 3'd3; #1;
        checks++; if (log_addr !== 32'd24 || log_data !== 32'd6) begin errors++; $display("FAIL log_idx3 got (%0d,%0d) exp (24,6)", log_addr, log_data); end
        log_idx = 3'd0;
    endtask

    task automatic test_reset_after_pass();
        do_reset();
        ticks(4);
        store(32'h20, 32'hAB, MEM_MASK_WORD);
        store(32'hF00, 32'h1, MEM_MASK_WORD);
        checks++; if (status !== SIM_PASS) begin errors++; $display("FAIL rap_pass got %0d exp %0d", status, SIM_PASS); end
        rst = 1'b1;
        tick();
        log_idx = 3'd0; #1;
        checks++; if (status !== SIM_RUN || done !== 1'b0) begin errors++; $display("FAIL rap_status got (%0d,%0b) exp (0,0)", status, done); end
        checks++; if (cycle_count !== 32'd0) begin errors++; $display("FAIL rap_cycle got %0d exp 0", cycle_count); end
        checks++; if (log_count !== 4'd0) begin errors++; $display("FAIL rap_log_count got %0d exp 0", log_count); end
        checks++; if (log_addr !== 32'd0 || log_data !== 32'd0) begin errors++; $display("FAIL rap_idx0 got (%0h,%0h) exp (0,0)", log_addr, log_data); end
        rst = 1'b0;
        tick();
        checks++; if (cycle_count !== 32'd1) begin errors++; $display("FAIL rap_restart got %0d exp 1", cycle_count); end
    endtask

    initial begin
        test_reset();
        test_pass();
        test_fail();
        test_timeout();
        test_hang();
        test_hit_beats_hang();
        test_hang_beats_timeout();
        test_log_wrap();
        test_reset_after_pass();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
